// File: rtl/mem_1r1w_bist.sv
// March BIST controller for a 1R1W SRAM wrapper: runs a six-element March sequence and flags read mismatches.
// Define MEM_BIST_DIAG_EN to capture the address, element and XOR syndrome of the first failure.
module mem_1r1w_bist #(
  parameter int DEPTH  = 48,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [WIDTH-1:0]  R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [WIDTH-1:0]  W0_data,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [WIDTH-1:0]  fail_xor
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;

  logic              two_cycle, down, step, elem_end, accept;
  logic              r_en, w_en, w_bit, exp_bit;
  logic [2:0]        elem;

  logic [ADDR_W-1:0] r_addr_q, w_addr_q;
  logic [WIDTH-1:0]  w_data_q;
  logic              cmp_valid;
  logic [WIDTH-1:0]  cmp_exp;
  logic [2:0]        cmp_elem;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      phase <= phase_n;
    end
  end

  // Two-cycle elements read in phase 0 and write the same address in phase 1.
  always_comb begin
    two_cycle = (state == M1) || (state == M2) || (state == M3) || (state == M4);
    down      = (state == M3) || (state == M4);
    step      = !two_cycle || phase;
    elem_end  = step && (down ? (addr == '0) : (addr == LAST));
    accept    = (state == IDLE) && start;
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    phase_n = phase;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        if (two_cycle) phase_n = ~phase;
        if (elem_end) begin
          case (state)
            M0:      begin state_n = M1;    addr_n = '0;   end
            M1:      begin state_n = M2;    addr_n = '0;   end
            M2:      begin state_n = M3;    addr_n = LAST; end
            M3:      begin state_n = M4;    addr_n = LAST; end
            M4:      begin state_n = M5;    addr_n = '0;   end
            default: begin state_n = FLUSH; addr_n = '0;   end
          endcase
        end else if (step) begin
          addr_n = down ? addr - 1'b1 : addr + 1'b1;
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    r_en    = 1'b0;
    w_en    = 1'b0;
    w_bit   = 1'b0;
    exp_bit = 1'b0;
    elem    = 3'd0;
    busy    = (state != IDLE) && (state != DONE);
    case (state)
      M0: begin
        elem = 3'd0;
        w_en = 1'b1;
      end
      M1, M3: begin
        elem  = (state == M1) ? 3'd1 : 3'd3;
        r_en  = !phase;
        w_en  = phase;
        w_bit = 1'b1;
      end
      M2, M4: begin
        elem    = (state == M2) ? 3'd2 : 3'd4;
        r_en    = !phase;
        w_en    = phase;
        exp_bit = 1'b1;
      end
      M5: begin
        elem = 3'd5;
        r_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Port addresses and data hold their last enabled value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      if (r_en) r_addr_q <= addr;
      if (w_en) begin
        w_addr_q <= addr;
        w_data_q <= {WIDTH{w_bit}};
      end
    end
  end

  assign R0_en   = r_en;
  assign W0_en   = w_en;
  assign R0_addr = r_en ? addr : r_addr_q;
  assign W0_addr = w_en ? addr : w_addr_q;
  assign W0_data = w_en ? {WIDTH{w_bit}} : w_data_q;

  assign mismatch = cmp_valid && (R0_data != cmp_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_elem  <= 3'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      cmp_valid <= r_en;
      cmp_exp   <= {WIDTH{exp_bit}};
      cmp_elem  <= elem;
      if (accept) begin
        done <= 1'b0;
        fail <= 1'b0;
      end else begin
        if (mismatch)        fail <= 1'b1;
        if (state == FLUSH)  done <= 1'b1;
      end
    end
  end

`ifdef MEM_BIST_DIAG_EN
  logic [ADDR_W-1:0] cmp_addr;
  logic [ADDR_W-1:0] diag_addr;
  logic [2:0]        diag_elem;
  logic [WIDTH-1:0]  diag_xor;

  // Only the first mismatch after start is recorded; fail doubles as the "already captured" flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_addr  <= '0;
      diag_addr <= '0;
      diag_elem <= 3'd0;
      diag_xor  <= '0;
    end else begin
      cmp_addr <= addr;
      if (accept) begin
        diag_addr <= '0;
        diag_elem <= 3'd0;
        diag_xor  <= '0;
      end else if (mismatch && !fail) begin
        diag_addr <= cmp_addr;
        diag_elem <= cmp_elem;
        diag_xor  <= R0_data ^ cmp_exp;
      end
    end
  end

  assign fail_addr = diag_addr;
  assign fail_elem = diag_elem;
  assign fail_xor  = diag_xor;
`else
  assign fail_addr = '0;
  assign fail_elem = 3'd0;
  assign fail_xor  = '0;
`endif

endmodule

// File: tb/tb_mem_1r1w_bist.sv
// Self-checking bench for mem_1r1w_bist: behavioural SRAM with optional stuck-at fault and a per-cycle port scoreboard.
module tb_mem_1r1w_bist;

  localparam int DEPTH  = 48;
  localparam int WIDTH  = 64;
  localparam int ADDR_W = 6;
  localparam int ACT    = 10 * DEPTH;
  localparam logic [ADDR_W-1:0] FAULT_ADDR = ADDR_W'(5);
  localparam logic [WIDTH-1:0]  FAULT_MASK = 64'h80;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, fail;
  logic [ADDR_W-1:0] R0_addr, W0_addr, fail_addr;
  logic              R0_en, W0_en;
  logic [WIDTH-1:0]  R0_data, W0_data, fail_xor;
  logic [2:0]        fail_elem;

  logic [WIDTH-1:0]  mem [DEPTH];
  bit                faultOn = 1'b0;
  int                checks = 0;
  int                failures = 0;
  logic [127:0]      sbQ [$];

  always #5 clk = ~clk;

  mem_1r1w_bist #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_xor(fail_xor)
  );

  // Behavioural 1R1W memory; the fault forces bit 7 of one word high on read.
  always @(posedge clk) begin
    if (W0_en && int'(W0_addr) < DEPTH) mem[W0_addr] <= W0_data;
    if (R0_en) begin
      if (int'(R0_addr) < DEPTH)
        R0_data <= mem[R0_addr] | ((faultOn && R0_addr == FAULT_ADDR) ? FAULT_MASK : '0);
      else
        R0_data <= '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] portView(input logic re, input logic we,
                                            input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa,
                                            input logic [WIDTH-1:0] wd);
    logic [127:0] v;
    v = '0;
    v[0] = re;
    v[1] = we;
    if (re) v[2 +: ADDR_W] = ra;
    if (we) begin
      v[8 +: ADDR_W] = wa;
      v[16 +: WIDTH] = wd;
    end
    return v;
  endfunction

  // Expected port activity for one full March run, one entry per cycle.
  task automatic pushMarch();
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] zeros;
    ones  = '1;
    zeros = '0;
    for (int a = 0; a < DEPTH; a++)
      sbQ.push_back(portView(1'b0, 1'b1, '0, ADDR_W'(a), zeros));
    for (int a = 0; a < DEPTH; a++) begin
      sbQ.push_back(portView(1'b1, 1'b0, ADDR_W'(a), '0, zeros));
      sbQ.push_back(portView(1'b0, 1'b1, '0, ADDR_W'(a), ones));
    end
    for (int a = 0; a < DEPTH; a++) begin
      sbQ.push_back(portView(1'b1, 1'b0, ADDR_W'(a), '0, zeros));
      sbQ.push_back(portView(1'b0, 1'b1, '0, ADDR_W'(a), zeros));
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      sbQ.push_back(portView(1'b1, 1'b0, ADDR_W'(a), '0, zeros));
      sbQ.push_back(portView(1'b0, 1'b1, '0, ADDR_W'(a), ones));
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      sbQ.push_back(portView(1'b1, 1'b0, ADDR_W'(a), '0, zeros));
      sbQ.push_back(portView(1'b0, 1'b1, '0, ADDR_W'(a), zeros));
    end
    for (int a = 0; a < DEPTH; a++)
      sbQ.push_back(portView(1'b1, 1'b0, ADDR_W'(a), '0, zeros));
  endtask

  task automatic applyStimulus();
    pushMarch();
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkPorts(input int c);
    logic [127:0] exp;
    checkOutput("sb_level", 128'(sbQ.size()), 128'(ACT - c + 1));
    if (sbQ.size() > 0) begin
      exp = sbQ.pop_front();
      checkOutput("port_seq", portView(R0_en, W0_en, R0_addr, W0_addr, W0_data), exp);
    end
  endtask

  task automatic runBody(input int strayAt, input bit holdStart, input bit expFail);
    int rdCnt = 0;
    int wrCnt = 0;
    int badAddr = 0;
    logic [ADDR_W-1:0] expDA;
    logic [2:0]        expDE;
    logic [WIDTH-1:0]  expDX;
    for (int c = 1; c <= ACT; c++) begin
      if (c == 1) begin
        checkOutput("busy_on", 128'(busy), 128'(1));
        checkOutput("done_cleared", 128'(done), 128'(0));
        checkOutput("fail_cleared", 128'(fail), 128'(0));
      end
      checkPorts(c);
      if (R0_en === 1'b1) rdCnt++;
      if (W0_en === 1'b1) wrCnt++;
      if ((R0_en && int'(R0_addr) >= DEPTH) || (W0_en && int'(W0_addr) >= DEPTH)) badAddr++;
      start = holdStart || (c == strayAt);
      @(negedge clk);
    end
    checkOutput("flush_busy", 128'(busy), 128'(1));
    checkOutput("flush_done", 128'(done), 128'(0));
    checkOutput("flush_quiet", 128'({R0_en, W0_en}), 128'(0));
    @(negedge clk);
    checkOutput("done_set", 128'(done), 128'(1));
    checkOutput("busy_off", 128'(busy), 128'(0));
    checkOutput("fail_flag", 128'(fail), 128'(expFail));
    checkOutput("read_count", 128'(rdCnt), 128'(5 * DEPTH));
    checkOutput("write_count", 128'(wrCnt), 128'(5 * DEPTH));
    checkOutput("bad_addr", 128'(badAddr), 128'(0));
`ifdef MEM_BIST_DIAG_EN
    expDA = expFail ? FAULT_ADDR : '0;
    expDE = expFail ? 3'd1 : 3'd0;
    expDX = expFail ? FAULT_MASK : '0;
`else
    expDA = '0;
    expDE = 3'd0;
    expDX = '0;
`endif
    checkOutput("fail_addr", 128'(fail_addr), 128'(expDA));
    checkOutput("fail_elem", 128'(fail_elem), 128'(expDE));
    checkOutput("fail_xor", 128'(fail_xor), 128'(expDX));
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'h5A5A_C3C3_0F0F_9696;
    R0_data = '0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_done", 128'(done), 128'(0));
    checkOutput("rst_fail", 128'(fail), 128'(0));
    checkOutput("rst_en", 128'({R0_en, W0_en}), 128'(0));
    checkOutput("rst_addr", 128'({R0_addr, W0_addr}), 128'(0));
    checkOutput("rst_wdata", 128'(W0_data), 128'(0));
    checkOutput("rst_diag", 128'({fail_addr, fail_elem, fail_xor}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] clean run with a stray start at cycle 100");
    applyStimulus();
    runBody(100, 1'b0, 1'b0);

    $display("[TB] run with bit 7 of word 5 stuck high");
    faultOn = 1'b1;
    @(negedge clk);
    applyStimulus();
    runBody(0, 1'b0, 1'b1);

    $display("[TB] reset asserted at cycle 200 of a faulty run");
    @(negedge clk);
    applyStimulus();
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      checkPorts(c);
      if (c < 200) @(negedge clk);
    end
    checkOutput("pre_reset_fail", 128'(fail), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_en", 128'({R0_en, W0_en}), 128'(0));
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_done", 128'(done), 128'(0));
    checkOutput("abort_fail", 128'(fail), 128'(0));
    checkOutput("abort_diag", 128'({fail_addr, fail_elem, fail_xor}), 128'(0));
    @(negedge clk);
    checkOutput("abort_hold_en", 128'({R0_en, W0_en}), 128'(0));
    rst_n = 1'b1;
    sbQ.delete();
    faultOn = 1'b0;
    @(negedge clk);

    $display("[TB] start held high across two back-to-back runs");
    applyStimulus();
    runBody(0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("idle_done_sticky", 128'(done), 128'(1));
    checkOutput("idle_busy", 128'(busy), 128'(0));
    pushMarch();
    @(negedge clk);
    runBody(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
